// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// It drives the register enables and bubble-insert controls, sequences the
// multi-cycle multiplier, and counts the cycles in which the PC is held.
//
//   state    | meaning
//   RUN      | normal issue; a multi-cycle MUL arriving in EX starts a freeze
//   MUL_BUSY | MUL occupying EX; mul_cnt freeze cycles remain before release
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_rb_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [3:0]        ex_mem_read,
    input  logic              ex_is_mul,
    input  logic              ex_pcsrc,
    input  logic              mem_stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mul_busy,
    output logic [31:0]       stall_count
);

    typedef enum logic {RUN, MUL_BUSY} state_t;

    // The first MUL cycle is spent in RUN and the release cycle in MUL_BUSY
    // with mul_cnt=0, so the counter is loaded with MUL_CYCLES-2.
    localparam logic       MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] mul_cnt, mul_cnt_nxt;
    logic       load_use;
    logic       mul_freeze;

    assign load_use = (ex_mem_read != 4'd0) && (ex_rd != '0) &&
                      ((id_ra == ex_rd) || (id_rb_used && (id_rb == ex_rd)));

    assign mul_freeze = ((state == RUN) && ex_is_mul && MUL_MULTI) ||
                        ((state == MUL_BUSY) && (mul_cnt != 4'd0));

    // State and multiplier counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    // Next-state and prioritised stall/flush decode
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mul_busy    = (state == MUL_BUSY);

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            mul_busy    = 1'b0;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            if (mul_freeze) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
            end else if (ex_pcsrc) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end

            // A MUL still in EX during the release cycle must not retrigger,
            // which holds because the start condition is only checked in RUN.
            case (state)
                RUN: begin
                    if (ex_is_mul && MUL_MULTI) begin
                        state_nxt   = MUL_BUSY;
                        mul_cnt_nxt = MUL_LOAD;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt != 4'd0) begin
                        mul_cnt_nxt = mul_cnt - 4'd1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt   = RUN;
                    mul_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if (!pc_en && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three builds (MUL_CYCLES 3, 4, 1) share the
// same stimulus; a cycle-level model tracks how long the current MUL has sat
// in EX and the stall count, and is compared on every cycle. Directed
// sequences with literal expectations pin the model.
module tb_pipeline_hazard_ctrl;

    localparam int NI = 3;
    localparam int MC [NI] = '{3, 4, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_ra, id_rb, ex_rd;
    logic       id_rb_used;
    logic [3:0] ex_mem_read;
    logic       ex_is_mul, ex_pcsrc, mem_stall;

    // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes, mul_busy}
    logic [8:0]  outv [NI];
    logic [31:0] sc   [NI];

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    int          age [NI];
    logic [31:0] cnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
        logic ifid_flush, idex_flush, exmem_flush, mul_busy;
        logic [31:0] stall_count;
        pipeline_hazard_ctrl #(.MUL_CYCLES(MC[g]), .REG_AW(5)) dut (
            .clk(clk), .reset(reset),
            .id_ra(id_ra), .id_rb(id_rb), .id_rb_used(id_rb_used),
            .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
            .ex_pcsrc(ex_pcsrc), .mem_stall(mem_stall),
            .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
            .exmem_en(exmem_en), .memwb_en(memwb_en),
            .ifid_flush(ifid_flush), .idex_flush(idex_flush),
            .exmem_flush(exmem_flush), .mul_busy(mul_busy),
            .stall_count(stall_count)
        );
        assign outv[g] = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush, exmem_flush, mul_busy};
        assign sc[g]   = stall_count;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model_out(input int k);
        logic busy, lu, frz;
        busy = (age[k] > 0);
        lu   = (ex_mem_read != 0) && (ex_rd != 0) &&
               ((id_ra == ex_rd) || (id_rb_used && (id_rb == ex_rd)));
        frz  = (age[k] == 0 && ex_is_mul && MC[k] > 1) ||
               (age[k] > 0 && age[k] < MC[k] - 1);
        if (reset)          return 9'b11111_111_0;
        else if (mem_stall) return {8'b0, busy};
        else if (frz)       return {8'b00011_001, busy};
        else if (ex_pcsrc)  return {8'b11111_110, busy};
        else if (lu)        return {8'b00111_010, busy};
        else                return {8'b11111_000, busy};
    endfunction

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < NI; k++) begin
                logic [8:0] e;
                e = model_out(k);
                chk($sformatf("outputs[mc=%0d]", MC[k]), 32'(outv[k]), 32'(e));
                chk($sformatf("stall_count[mc=%0d]", MC[k]), sc[k], cnt[k]);
                if (reset) begin
                    age[k] = 0;
                    cnt[k] = 0;
                end else begin
                    if (!e[8] && cnt[k] != 32'hFFFF_FFFF) cnt[k] = cnt[k] + 1;
                    if (!mem_stall) begin
                        if (age[k] == 0) begin
                            if (ex_is_mul && MC[k] > 1) age[k] = 1;
                        end else if (age[k] < MC[k] - 1) age[k] = age[k] + 1;
                        else age[k] = 0;
                    end
                end
            end
        end
    end

    task automatic idle();
        reset = 0; id_ra = 0; id_rb = 0; id_rb_used = 0; ex_rd = 0;
        ex_mem_read = 0; ex_is_mul = 0; ex_pcsrc = 0; mem_stall = 0;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            age[k] = 0;
            cnt[k] = 0;
        end
        idle();
        reset = 1;
        tick();
        model_on = 1'b1;
        tick();
        idle();
        #1;
        chk("idle_after_reset", 32'(outv[0]), 32'(9'b11111_000_0));
        chk("idle_count", sc[0], 0);

        // Load-use bubble
        ex_mem_read = 4'b1111; ex_rd = 5; id_ra = 5;
        #1 chk("load_use", 32'(outv[0]), 32'(9'b00111_010_0));
        tick(); idle();
        #1 chk("after_load_use", 32'(outv[0]), 32'(9'b11111_000_0));
        chk("load_use_count", sc[0], 1);
        ex_mem_read = 4'b1111; ex_rd = 0; id_ra = 0;
        #1 chk("load_r0_no_stall", 32'(outv[0]), 32'(9'b11111_000_0));
        tick(); idle();
        #1 chk("load_r0_count", sc[0], 1);
        ex_mem_read = 4'b0001; ex_rd = 7; id_rb = 7; id_rb_used = 0;
        #1 chk("rb_unused_no_stall", 32'(outv[0]), 32'(9'b11111_000_0));
        id_rb_used = 1;
        #1 chk("rb_used_stall", 32'(outv[0]), 32'(9'b00111_010_0));
        tick();

        // MUL, MUL_CYCLES=3
        reset_pulse();
        ex_is_mul = 1;
        #1 chk("mul_c1", 32'(outv[0]), 32'(9'b00011_001_0));
        chk("mul1_c1", 32'(outv[2]), 32'(9'b11111_000_0));
        tick();
        #1 chk("mul_c2", 32'(outv[0]), 32'(9'b00011_001_1));
        tick();
        #1 chk("mul_c3", 32'(outv[0]), 32'(9'b11111_000_1));
        tick(); idle();
        #1 chk("mul_done", 32'(outv[0]), 32'(9'b11111_000_0));
        chk("mul_count", sc[0], 2);
        chk("mul1_count", sc[2], 0);

        // MUL with data-memory hold in its second cycle
        reset_pulse();
        ex_is_mul = 1;
        tick();
        mem_stall = 1;
        #1 chk("mul_memstall", 32'(outv[0]), 32'(9'b00000_000_1));
        tick();
        mem_stall = 0;
        #1 chk("mul_ms_c3", 32'(outv[0]), 32'(9'b00011_001_1));
        tick();
        #1 chk("mul_ms_c4", 32'(outv[0]), 32'(9'b11111_000_1));
        tick(); idle();
        #1 chk("mul_ms_count", sc[0], 3);

        // Taken JAL
        reset_pulse();
        ex_pcsrc = 1;
        #1 chk("pcsrc", 32'(outv[0]), 32'(9'b11111_110_0));
        tick(); idle();
        #1 chk("pcsrc_count", sc[0], 0);

        // Reset during a MUL_CYCLES=4 sequence
        ex_is_mul = 1;
        tick();
        #1 chk("mul4_c2_busy", 32'(outv[1]), 32'(9'b00011_001_1));
        reset = 1;
        #1 chk("mul4_reset", 32'(outv[1]), 32'(9'b11111_111_0));
        tick(); idle();
        #1 chk("mul4_after_reset", 32'(outv[1]), 32'(9'b11111_000_0));
        chk("mul4_count", sc[1], 0);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset       = ($urandom_range(63) == 0);
            mem_stall   = ($urandom_range(7) == 0);
            id_ra       = 5'($urandom_range(3));
            id_rb       = 5'($urandom_range(3));
            id_rb_used  = 1'($urandom);
            ex_rd       = 5'($urandom_range(3));
            ex_mem_read = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
            ex_is_mul   = ($urandom_range(4) == 0);
            ex_pcsrc    = ($urandom_range(7) == 0);
            if (ex_pcsrc) begin
                ex_mem_read = 0;
                ex_is_mul   = 0;
            end
        end
        tick(); idle();
        tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
